// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point FFT butterfly stages: word packing and
// the bit-reversed butterfly pair table used by stage 1.
package fft16_pkg;

  localparam int DW  = 16;
  localparam int NBF = 8;
  localparam int NS  = 2 * NBF;

  localparam int RE_MSB = 2*DW - 1;
  localparam int RE_LSB = DW;
  localparam int IM_MSB = DW - 1;
  localparam int IM_LSB = 0;

  typedef logic [2*DW-1:0] word_t;
  typedef logic [DW-1:0]   comp_t;

  function automatic comp_t re_of(input word_t w);
    return w[RE_MSB:RE_LSB];
  endfunction

  function automatic comp_t im_of(input word_t w);
    return w[IM_MSB:IM_LSB];
  endfunction

  function automatic word_t pack_word(input comp_t re, input comp_t im);
    return {re, im};
  endfunction

  // First operand of butterfly k in bit-reversed input order
  function automatic logic [3:0] br16_p(input logic [2:0] k);
    logic [3:0] p;
    case (k)
      3'd0:    p = 4'd0;
      3'd1:    p = 4'd4;
      3'd2:    p = 4'd2;
      3'd3:    p = 4'd6;
      3'd4:    p = 4'd1;
      3'd5:    p = 4'd5;
      3'd6:    p = 4'd3;
      default: p = 4'd7;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] br16_q(input logic [2:0] k);
    return br16_p(k) + 4'd8;
  endfunction

endpackage

// File: rtl/fft16_stage1_bfly_if.sv
// Frame bus between loads_data, stage 1 and stage 2: sample inputs, result
// outputs and the frame handshake/status flags.
interface fft16_stage1_bfly_if;
  import fft16_pkg::*;

  logic  rdy_load;
  word_t x [NS];
  word_t y [NS];
  logic  rdy_s1;
  logic  valid_s1;
  logic  busy;
  logic  overrun;

  modport master (
    output rdy_load, x,
    input  y, rdy_s1, valid_s1, busy, overrun
  );

  modport slave (
    input  rdy_load, x,
    output y, rdy_s1, valid_s1, busy, overrun
  );

endinterface

// File: rtl/fft_bfly_w0.sv
// Combinational radix-2 butterfly with twiddle W^0, operands picked by k.
// FFT_STAGE1_SCALE_EN selects halving of each result instead of saturation.
module fft_bfly_w0
  import fft16_pkg::*;
(
  input  word_t      frame_buf [NS],
  input  logic [2:0] k,
  output word_t      sum,
  output word_t      dif
);

  word_t a;
  word_t b;
  logic signed [DW:0] re_sum;
  logic signed [DW:0] re_dif;
  logic signed [DW:0] im_sum;
  logic signed [DW:0] im_dif;

  function automatic comp_t reduce(input logic signed [DW:0] v);
`ifdef FFT_STAGE1_SCALE_EN
    return v[DW:1];
`else
    if (v[DW] != v[DW-1])
      return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      return v[DW-1:0];
`endif
  endfunction

  function automatic logic signed [DW:0] sx(input comp_t c);
    return {c[DW-1], c};
  endfunction

  always_comb begin
    a = frame_buf[br16_p(k)];
    b = frame_buf[br16_q(k)];
    re_sum = sx(re_of(a)) + sx(re_of(b));
    re_dif = sx(re_of(a)) - sx(re_of(b));
    im_sum = sx(im_of(a)) + sx(im_of(b));
    im_dif = sx(im_of(a)) - sx(im_of(b));
    sum = pack_word(reduce(re_sum), reduce(im_sum));
    dif = pack_word(reduce(re_dif), reduce(im_dif));
  end

endmodule

// File: rtl/fft16_stage1_bfly.sv
// Stage 1 of the 16-point DIT FFT: captures a frame on a rdy_load rise and runs
// eight W^0 butterflies, one per cycle. Build option: FFT_STAGE1_SCALE_EN.
//
//  state  | meaning
//  IDLE   | waiting for a rdy_load rise; y holds the last complete frame
//  RUN    | butterfly k written to y[2k], y[2k+1] each cycle
module fft16_stage1_bfly
  import fft16_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  fft16_stage1_bfly_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0] state;
  logic [2:0] k;
  logic       rdy_load_q;
  logic       start;
  word_t      frame_buf [NS];
  word_t      y_r [NS];
  word_t      bf_sum;
  word_t      bf_dif;
  logic       rdy_s1_r;
  logic       valid_s1_r;
  logic       busy_r;
  logic       overrun_r;

  assign start = bus.rdy_load & ~rdy_load_q;

  fft_bfly_w0 u_bfly (
    .frame_buf (frame_buf),
    .k         (k),
    .sum       (bf_sum),
    .dif       (bf_dif)
  );

  // Edge register resets high so a level already present at release is not a start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      k          <= 3'd0;
      rdy_load_q <= 1'b1;
      rdy_s1_r   <= 1'b0;
      valid_s1_r <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        frame_buf[i] <= '0;
        y_r[i]       <= '0;
      end
    end else begin
      rdy_load_q <= bus.rdy_load;
      rdy_s1_r   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NS; i++)
              frame_buf[i] <= bus.x[i];
            busy_r     <= 1'b1;
            valid_s1_r <= 1'b0;
            k          <= 3'd0;
            state      <= S_RUN;
          end
        end
        default: begin
          y_r[{k, 1'b0}] <= bf_sum;
          y_r[{k, 1'b1}] <= bf_dif;
          // A rise during RUN, including the final cycle, is dropped, not queued
          if (start)
            overrun_r <= 1'b1;
          if (k == 3'd7) begin
            rdy_s1_r   <= 1'b1;
            valid_s1_r <= 1'b1;
            busy_r     <= 1'b0;
            k          <= 3'd0;
            state      <= S_IDLE;
          end else begin
            k <= k + 3'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NS; i++)
      bus.y[i] = y_r[i];
    bus.rdy_s1   = rdy_s1_r;
    bus.valid_s1 = valid_s1_r;
    bus.busy     = busy_r;
    bus.overrun  = overrun_r;
  end

endmodule

// File: tb/tb_fft16_stage1_bfly.sv
// Bench for fft16_stage1_bfly: frame-level reference model plus directed frames
// with hand-computed results.
module tb_fft16_stage1_bfly;
  import fft16_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft16_stage1_bfly_if bus ();

  fft16_stage1_bfly dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t pk(input int re, input int im);
    logic [31:0] r;
    logic [31:0] m;
    r = re;
    m = im;
    return {r[15:0], m[15:0]};
  endfunction

  function automatic int bitrev4(input int v);
    int r = 0;
    for (int b = 0; b < 4; b++)
      if (((v >> b) & 1) != 0) r |= (1 << (3 - b));
    return r;
  endfunction

  function automatic int fit(input int s);
`ifdef FFT_STAGE1_SCALE_EN
    return s >>> 1;
`else
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`endif
  endfunction

  // Reference model: DIT stage 1 output n=2k/2k+1 combines bit-reversed inputs
  word_t m_x [NS];
  word_t m_y [NS];
  int    m_cnt = 0;
  bit    m_prev = 1'b1, m_busy = 1'b0, m_valid = 1'b0, m_rdy = 1'b0, m_ovr = 1'b0;

  task automatic model_frame();
    int ar, ai, br, bi, p, q;
    for (int k = 0; k < NBF; k++) begin
      p = bitrev4(2*k);
      q = bitrev4(2*k + 1);
      ar = $signed(m_x[p][31:16]); ai = $signed(m_x[p][15:0]);
      br = $signed(m_x[q][31:16]); bi = $signed(m_x[q][15:0]);
      m_y[2*k]   = pk(fit(ar + br), fit(ai + bi));
      m_y[2*k+1] = pk(fit(ar - br), fit(ai - bi));
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_prev = 1'b1; m_cnt = 0; m_busy = 1'b0; m_valid = 1'b0; m_rdy = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < NS; i++) m_y[i] = '0;
    end else begin
      bit st;
      st = bus.rdy_load && !m_prev;
      m_prev = bus.rdy_load;
      m_rdy = 1'b0;
      if (m_cnt == 0) begin
        if (st) begin
          for (int i = 0; i < NS; i++) m_x[i] = bus.x[i];
          m_cnt = 1; m_busy = 1'b1; m_valid = 1'b0;
        end
      end else begin
        if (st) m_ovr = 1'b1;
        if (m_cnt == 8) begin
          model_frame();
          m_cnt = 0; m_busy = 1'b0; m_valid = 1'b1; m_rdy = 1'b1;
        end else m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_rdy_s1",   {31'd0, bus.rdy_s1},   {31'd0, m_rdy});
      chk("m_valid_s1", {31'd0, bus.valid_s1}, {31'd0, m_valid});
      chk("m_busy",     {31'd0, bus.busy},     {31'd0, m_busy});
      chk("m_overrun",  {31'd0, bus.overrun},  {31'd0, m_ovr});
      if (m_valid || !reset_n)
        for (int i = 0; i < NS; i++) chk($sformatf("m_y%0d", i), bus.y[i], m_y[i]);
    end
  end

  task automatic clear_x();
    for (int i = 0; i < NS; i++) bus.x[i] = '0;
  endtask

  // Raise rdy_load, then watch ncyc edges after the capture edge
  task automatic frame_go(input int drop_at, input int rerise_at, input int ncyc,
                          output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    @(negedge clk);
    bus.rdy_load = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c == drop_at) bus.rdy_load = 1'b0;
      if (c == rerise_at) bus.rdy_load = 1'b1;
      if (bus.rdy_s1) begin
        pulses++;
        if (lat < 0) lat = c;
      end
    end
    @(negedge clk);
    bus.rdy_load = 1'b0;
    @(negedge clk);
  endtask

  int lat, pulses;

  initial begin
    bus.rdy_load = 1'b1;
    clear_x();
    repeat (3) @(negedge clk);
    chk("rst_rdy_s1", {31'd0, bus.rdy_s1}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid_s1}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("rst_y0", bus.y[0], 32'd0);
    cmp_en = 1'b1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("lvl_at_release_busy", {31'd0, bus.busy}, 32'd0);
    chk("lvl_at_release_valid", {31'd0, bus.valid_s1}, 32'd0);
    bus.rdy_load = 1'b0;
    @(negedge clk);

    // Basic frame
    bus.x[0] = pk(100, 20);
    bus.x[8] = pk(30, -5);
    frame_go(1, -1, 12, lat, pulses);
    chk("basic_latency", lat, 8);
    chk("basic_pulses", pulses, 1);
`ifdef FFT_STAGE1_SCALE_EN
    chk("basic_y0", bus.y[0], pk(65, 7));
    chk("basic_y1", bus.y[1], pk(35, 12));
`else
    chk("basic_y0", bus.y[0], pk(130, 15));
    chk("basic_y1", bus.y[1], pk(70, 25));
`endif
    chk("basic_y5", bus.y[5], 32'd0);
    chk("basic_valid", {31'd0, bus.valid_s1}, 32'd1);
    chk("basic_overrun", {31'd0, bus.overrun}, 32'd0);

    // Ordering
    for (int i = 0; i < NS; i++) bus.x[i] = pk(i, -i);
    frame_go(1, -1, 12, lat, pulses);
    chk("ord_latency", lat, 8);
`ifdef FFT_STAGE1_SCALE_EN
    chk("ord_y2", bus.y[2], pk(8, -8));
    chk("ord_y3", bus.y[3], pk(-4, 4));
    chk("ord_y8", bus.y[8], pk(5, -5));
    chk("ord_y14", bus.y[14], pk(11, -11));
`else
    chk("ord_y2", bus.y[2], pk(16, -16));
    chk("ord_y3", bus.y[3], pk(-8, 8));
    chk("ord_y8", bus.y[8], pk(10, -10));
    chk("ord_y9", bus.y[9], pk(-8, 8));
    chk("ord_y14", bus.y[14], pk(22, -22));
    chk("ord_y15", bus.y[15], pk(-8, 8));
`endif

    // Overflow
    clear_x();
    bus.x[0] = pk(32767, 0);
    bus.x[8] = pk(1, 0);
    bus.x[1] = pk(-32768, 0);
    bus.x[9] = pk(1, 0);
    frame_go(1, -1, 12, lat, pulses);
`ifdef FFT_STAGE1_SCALE_EN
    chk("ovf_y0", bus.y[0], pk(16384, 0));
    chk("ovf_y9", bus.y[9], pk(-16385, 0));
`else
    chk("ovf_y0", bus.y[0], pk(32767, 0));
    chk("ovf_y9", bus.y[9], pk(-32768, 0));
`endif

    // Overrun: second rise at T+4
    clear_x();
    bus.x[0] = pk(100, 20);
    bus.x[8] = pk(30, -5);
    frame_go(1, 3, 20, lat, pulses);
    chk("ovr_latency", lat, 8);
    chk("ovr_pulses", pulses, 1);
    chk("ovr_flag", {31'd0, bus.overrun}, 32'd1);
`ifndef FFT_STAGE1_SCALE_EN
    chk("ovr_y0", bus.y[0], pk(130, 15));
`endif

    // Level held high for 30 cycles
    frame_go(-1, -1, 30, lat, pulses);
    chk("lvl_pulses", pulses, 1);
    chk("lvl_latency", lat, 8);

    // Reset mid-RUN at T+5
    bus.x[0] = pk(-7, 3);
    bus.x[8] = pk(2, 9);
    @(negedge clk);
    bus.rdy_load = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_valid", {31'd0, bus.valid_s1}, 32'd0);
    chk("midrst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("midrst_y0", bus.y[0], 32'd0);
    bus.rdy_load = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    frame_go(1, -1, 12, lat, pulses);
    chk("post_rst_latency", lat, 8);
`ifdef FFT_STAGE1_SCALE_EN
    chk("post_rst_y1", bus.y[1], pk(-5, -3));
`else
    chk("post_rst_y0", bus.y[0], pk(-5, 12));
    chk("post_rst_y1", bus.y[1], pk(-9, -6));
`endif

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft16_stage1_bfly.md
Name: fft16_stage1_bfly

Overview:
- First radix-2 DIT butterfly stage of the 16-point FFT.
- Sits directly downstream of loads_data. It captures the 16 complex samples x0..x15 when rdy_load rises.
- Runs one butterfly per cycle for 8 cycles, taking the inputs in bit-reversed order with twiddle W^0.
- Presents y0..y15 to stage 2 with a done pulse and a valid level.

Parameters:
- DW, 16, width of each real/imag component (sample word = 2*DW = 32 bits).
- NBF, 8, butterflies per frame (fixed for N=16; not to be overridden).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- rdy_load  input  1  loads_data frame-ready flag (level); a 0->1 transition starts a frame
- x0..x15  input  32 each  samples; [31:16] real, [15:0] imag, two's complement
- y0..y15  output  32 each  stage-1 results, same packing
- rdy_s1  output  1  one-cycle pulse: frame complete
- valid_s1  output  1  y0..y15 hold a complete frame
- busy  output  1  high while capturing or running
- overrun  output  1  sticky: a rdy_load rise arrived while busy

Behaviour:
- Reset (async, reset_n=0): all y=0, rdy_s1=0, valid_s1=0, busy=0, overrun=0, state=IDLE, counter k=0, rdy_load edge-detect register=1.
  - Edge register at 1 means a rdy_load already high at reset release does not start a frame.
- Reset mid-frame aborts immediately; no partial frame is ever flagged valid.
- Edge detect: start = rdy_load & ~rdy_load_q.
- FSM states: IDLE, RUN.
- IDLE:
  - On start, latch x0..x15 into an internal buffer at edge T.
  - Set busy=1, clear valid_s1, k=0, go to RUN.
- RUN (edges T+1..T+8):
  - Butterfly k: a=buf[p(k)], b=buf[q(k)].
  - Pairs (p,q) for k=0..7: (0,8) (4,12) (2,10) (6,14) (1,9) (5,13) (3,11) (7,15).
  - Writes y[2k]=a+b, y[2k+1]=a-b, computed per component, real and imag independently.
  - k increments by 1 each cycle.
  - At k=7: rdy_s1=1 for exactly one cycle (visible after edge T+8), valid_s1=1, busy=0, k wraps to 0, return to IDLE.
- Latency: result valid 8 cycles after the capture edge. A new frame may start on the cycle after rdy_s1 (frame period is 9 cycles minimum).
- During RUN, y words change progressively. Consumers use y only while valid_s1=1.
- A start while in RUN is ignored (the frame is not queued) and sets overrun=1. Only reset clears overrun.
- If start coincides with the final RUN cycle, it is also ignored and sets overrun.
- Arithmetic: sums and differences are formed at DW+1 bits, then reduced to DW bits per the optional feature below.

Optional Feature:
- Macro: FFT_STAGE1_SCALE_EN.
- Defined: each DW+1 result is arithmetically shifted right by 1 (bits [DW:1]). This gives a per-stage 1/2 scale and no overflow is possible.
- Undefined: the DW+1 result is saturated to [-2^(DW-1), 2^(DW-1)-1] with no scaling.

Decomposition:
- Shared package fft16_pkg: DW, the complex-word packing field positions, and the BR16 pair table (p,q per k).
  - The stage-2/3/4 blocks reuse the same package.
- One natural sub-module: fft_bfly_w0. It is combinational; it takes two complex words and returns sum and difference with the scale/saturate rule. Its input mux is selected by k.

Test Plan:
- Basic: x0={100,20}, x8={30,-5}, all others 0; pulse rdy_load 0->1. Required: rdy_s1 exactly 8 cycles after the capture edge; y0={130,15}, y1={70,25}, all other y=0, valid_s1=1, overrun=0. With FFT_STAGE1_SCALE_EN: y0={65,7}, y1={35,12}.
- Ordering: x_i={i,-i} for i=0..15. Required: y2={16,-16}, y3={-8,8}, y8={10,-10}, y9={-8,8}, y14={22,-22}, y15={-8,8}.
- Overflow: x0.re=32767, x8.re=1 gives y0.re=32767 saturated (16384 scaled). x1.re=-32768, x9.re=1 gives y9.re=-32768 saturated (-16385 scaled).
- Overrun: second 0->1 on rdy_load at T+4. Required: first frame completes unchanged at T+8, overrun=1, no second rdy_s1 follows.
- Level handling: rdy_load held high for 30 cycles. Required: exactly one rdy_s1; also, rdy_load already high at reset release starts no frame.
- Reset mid-RUN at T+5. Required: all outputs 0 asynchronously. After release, a fresh rdy_load rise produces a correct frame.
